// File: rtl/taxi_pkg.sv
// Shared definitions for the taxi meter: trip state encoding and BCD fare width.
package taxi_pkg;

  localparam int unsigned BcdW = 16;
  localparam logic [BcdW-1:0] MaxFareBcdDefault = 16'h9990;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StWait = 2'b10,
    StHold = 2'b11
  } meter_state_e;

endpackage

// File: rtl/taxi_pulse_gen.sv
// Registered 50%-duty pulse generator; the output comes straight from a flop so it can
// safely clock downstream logic.
module taxi_pulse_gen #(
  parameter int unsigned PERIOD = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic sync_clr,
  output logic pulse
);

  localparam int unsigned CntW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int unsigned Half = PERIOD / 2;

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            pulse_q, pulse_d;

  // cnt_d is the phase of the coming cycle; sync_clr makes that cycle phase 0.
  always_comb begin
    cnt_d = cnt_q;
    if (sync_clr) begin
      cnt_d = '0;
    end else if (cnt_q == CntW'(PERIOD - 1)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
    pulse_d = en && (cnt_d < CntW'(Half));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/taxi_meter_ctrl.sv
// Taxi meter trip sequencer: IDLE/RUN/WAIT/HOLD FSM, idle-timeout counter, sticky fare cap
// flag and accumulator clear. All outputs are registered from next-state values.
module taxi_meter_ctrl
  import taxi_pkg::*;
#(
  parameter int unsigned     WAIT_TIMEOUT = 50_000_000,
  parameter int unsigned     WAIT_UNIT    = 50_000_000,
  parameter logic [BcdW-1:0] MAX_FARE_BCD = MaxFareBcdDefault
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_btn,
  input  logic            stop_btn,
  input  logic            wheel_pulse,
  input  logic [BcdW-1:0] fare_total_bcd,
  output logic            dist_en,
  output logic            wait_en,
  output logic            wait_fare_pulse,
  output logic            max,
  output logic            clear,
  output logic [1:0]      meter_state
);

  localparam int unsigned IdleW = $clog2(WAIT_TIMEOUT);

  meter_state_e     state_q, state_d;
  logic [IdleW-1:0] idle_cnt_q, idle_cnt_d;
  logic             max_q, max_d;
  logic             clear_q, clear_d;
  logic             dist_en_q, wait_en_q;
  logic             pulse_en, pulse_sync_clr;

  always_comb begin
    state_d    = state_q;
    idle_cnt_d = '0;
    clear_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_btn) begin
          state_d = StRun;
          clear_d = 1'b1;
        end
      end
      StRun: begin
        if (stop_btn) begin
          state_d = StHold;
        end else if (wheel_pulse) begin
          idle_cnt_d = '0;
        end else if (idle_cnt_q == IdleW'(WAIT_TIMEOUT - 1)) begin
          state_d = StWait;
        end else begin
          idle_cnt_d = idle_cnt_q + IdleW'(1);
        end
      end
      StWait: begin
        if (stop_btn) begin
          state_d = StHold;
        end else if (wheel_pulse) begin
          state_d = StRun;
        end
      end
      StHold: begin
        if (stop_btn) begin
          state_d = StIdle;
          clear_d = 1'b1;
        end else if (start_btn) begin
          state_d = StRun;
          clear_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    // Packed BCD keeps numeric order, so a plain unsigned compare finds the cap.
    if (clear_d) begin
      max_d = 1'b0;
    end else begin
      max_d = max_q || (fare_total_bcd >= MAX_FARE_BCD);
    end

    pulse_en       = (state_d == StWait) && !max_d;
    pulse_sync_clr = (state_q != StWait);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      idle_cnt_q <= '0;
      max_q      <= 1'b0;
      clear_q    <= 1'b0;
      dist_en_q  <= 1'b0;
      wait_en_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      idle_cnt_q <= idle_cnt_d;
      max_q      <= max_d;
      clear_q    <= clear_d;
      dist_en_q  <= (state_d == StRun) && !max_d;
      wait_en_q  <= (state_d == StWait) && !max_d;
    end
  end

  taxi_pulse_gen #(
    .PERIOD (WAIT_UNIT)
  ) u_wait_pulse (
    .clk      (clk),
    .rst      (rst),
    .en       (pulse_en),
    .sync_clr (pulse_sync_clr),
    .pulse    (wait_fare_pulse)
  );

  assign dist_en     = dist_en_q;
  assign wait_en     = wait_en_q;
  assign max         = max_q;
  assign clear       = clear_q;
  assign meter_state = state_q;

endmodule
